// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scan driver with per-frame input snapshot
module seg_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 4,
   parameter int COMMON_ANODE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   din,
   input  logic [DIGITS-1:0]     blank,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  hold,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic INV = (COMMON_ANODE != 0);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   // Scan state
   logic [PW-1:0]        presc_q, presc_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 primed_q, primed_d;

   // Per-frame snapshot of the inputs
   logic [4*DIGITS-1:0]  sh_din_q, sh_din_d;
   logic [DIGITS-1:0]    sh_blank_q, sh_blank_d;
   logic [DIGITS-1:0]    sh_dp_q, sh_dp_d;

   // Registered pin drivers
   logic [6:0]           seg_q, seg_d;
   logic                 dp_q, dp_d;
   logic [DIGITS-1:0]    an_q, an_d;
   logic                 frame_done_q, frame_done_d;

   // Slot decode helpers
   logic                 presc_wrap;
   logic                 frame_end;
   logic [3:0]           cur_nib;
   logic                 cur_blank;
   logic                 cur_dp;
   logic [DIGITS-1:0]    an_act;
   logic [6:0]           seg_act;
   logic                 dp_act;

   // Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Next scan position and snapshot reload; the first edge after reset only primes the snapshot
   always_comb begin
      presc_wrap = primed_q && (presc_q == PRESC_LAST);
      frame_end  = presc_wrap && (idx_q == IDX_LAST);
      primed_d   = 1'b1;
      presc_d    = presc_q;
      idx_d      = idx_q;
      sh_din_d   = sh_din_q;
      sh_blank_d = sh_blank_q;
      sh_dp_d    = sh_dp_q;
      if (!primed_q) begin
         sh_din_d   = din;
         sh_blank_d = blank;
         sh_dp_d    = dp_in;
      end else begin
         presc_d = presc_wrap ? '0 : presc_q + 1'b1;
         if (presc_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end
         if (frame_end && !hold) begin
            sh_din_d   = din;
            sh_blank_d = blank;
            sh_dp_d    = dp_in;
         end
      end
      frame_done_d = frame_end;
   end

   // Select the current slot from the snapshot and form the polarity-corrected pin values
   always_comb begin
      cur_nib   = 4'h0;
      cur_blank = 1'b0;
      cur_dp    = 1'b0;
      an_act    = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            cur_nib   = sh_din_q[4*k +: 4];
            cur_blank = sh_blank_q[k];
            cur_dp    = sh_dp_q[k];
            an_act[k] = 1'b1;
         end
      end
      seg_act = hex7(cur_nib);
      dp_act  = cur_dp;
      // Blanked slots and the priming edge keep every pin at its inactive level
      if (!primed_q || cur_blank) begin
         seg_act = 7'h00;
         dp_act  = 1'b0;
         an_act  = '0;
      end
      seg_d = seg_act ^ {7{INV}};
      dp_d  = dp_act ^ INV;
      an_d  = an_act ^ {DIGITS{INV}};
   end

   // State and output registers; reset parks the pins at the inactive level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q      <= '0;
         idx_q        <= '0;
         primed_q     <= 1'b0;
         sh_din_q     <= '0;
         sh_blank_q   <= '0;
         sh_dp_q      <= '0;
         seg_q        <= {7{INV}};
         dp_q         <= INV;
         an_q         <= {DIGITS{INV}};
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         primed_q     <= primed_d;
         sh_din_q     <= sh_din_d;
         sh_blank_q   <= sh_blank_d;
         sh_dp_q      <= sh_dp_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - bench for seg_scan_driver, both polarities against a frame-level model
module tb_seg_scan_driver;

   localparam int ND = 4;
   localparam int SD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   din = 16'h1234;
   logic [3:0]    blank = 4'b0000;
   logic [3:0]    dp_in = 4'b0000;
   logic          hold = 1'b0;

   logic [6:0]    seg, seg_ca;
   logic          dp, dp_ca;
   logic [3:0]    an, an_ca;
   logic          frame_done, frame_done_ca;

   int total = 0;
   int bad = 0;
   int e = 0;

   seg_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .COMMON_ANODE(0)) dut (
      .clk(clk), .rst(rst), .din(din), .blank(blank), .dp_in(dp_in), .hold(hold),
      .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
   );

   seg_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .COMMON_ANODE(1)) dut_ca (
      .clk(clk), .rst(rst), .din(din), .blank(blank), .dp_in(dp_in), .hold(hold),
      .seg(seg_ca), .dp(dp_ca), .an(an_ca), .frame_done(frame_done_ca)
   );

   always #5 clk = ~clk;

   // edges since reset release
   always @(posedge clk or posedge rst) begin
      if (rst) e <= 0;
      else     e <= e + 1;
   end

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[v];
   endfunction

   // model: edge 1 primes, then position p = edges-2 selects slot (p/SD)%ND
   bit          m_primed = 1'b0;
   int          m_pos = 0;
   logic [15:0] m_din = '0;
   logic [3:0]  m_blank = '0;
   logic [3:0]  m_dp = '0;
   logic [6:0]  exp_seg = '0;
   logic        exp_dp = 1'b0;
   logic [3:0]  exp_an = '0;
   logic        exp_fd = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_primed <= 1'b0; m_pos <= 0;
         m_din <= '0; m_blank <= '0; m_dp <= '0;
         exp_seg <= '0; exp_dp <= 1'b0; exp_an <= '0; exp_fd <= 1'b0;
      end else if (!m_primed) begin
         m_primed <= 1'b1;
         m_din <= din; m_blank <= blank; m_dp <= dp_in;
         exp_seg <= '0; exp_dp <= 1'b0; exp_an <= '0; exp_fd <= 1'b0;
      end else begin
         if (m_blank[(m_pos / SD) % ND]) begin
            exp_seg <= '0; exp_dp <= 1'b0; exp_an <= '0;
         end else begin
            exp_seg <= hex7(m_din[4*((m_pos / SD) % ND) +: 4]);
            exp_dp  <= m_dp[(m_pos / SD) % ND];
            exp_an  <= 4'(1 << ((m_pos / SD) % ND));
         end
         exp_fd <= ((m_pos % (SD*ND)) == SD*ND - 1);
         if (((m_pos % (SD*ND)) == SD*ND - 1) && !hold) begin
            m_din <= din; m_blank <= blank; m_dp <= dp_in;
         end
         m_pos <= m_pos + 1;
      end
   end

   wire [6:0] exp_seg_ca = ~exp_seg;
   wire       exp_dp_ca  = ~exp_dp;
   wire [3:0] exp_an_ca  = ~exp_an;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, want);
      end
   endtask

   // every-cycle comparison against the model
   always @(negedge clk) begin
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("dp", 32'(dp), 32'(exp_dp));
      chk("an", 32'(an), 32'(exp_an));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("ca_seg", 32'(seg_ca), 32'(exp_seg_ca));
      chk("ca_dp", 32'(dp_ca), 32'(exp_dp_ca));
      chk("ca_an", 32'(an_ca), 32'(exp_an_ca));
      chk("ca_frame_done", 32'(frame_done_ca), 32'(exp_fd));
   end

   task automatic goto(input int target);
      for (int g = 0; g < 400 && e < target; g++) @(negedge clk);
      if (e != target) begin
         total++; bad++;
         $display("FAIL goto: reached edge %0d expected %0d", e, target);
      end
   endtask

   task automatic lit(input string name, input logic [3:0] w_an, input logic [6:0] w_seg, input logic w_dp);
      chk({name, "_an"}, 32'(an), 32'(w_an));
      chk({name, "_seg"}, 32'(seg), 32'(w_seg));
      chk({name, "_dp"}, 32'(dp), 32'(w_dp));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      // reset state, both polarities
      lit("rst", 4'b0000, 7'h00, 1'b0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      chk("rst_ca_an", 32'(an_ca), 32'hF);
      chk("rst_ca_seg", 32'(seg_ca), 32'h7F);
      chk("rst_ca_dp", 32'(dp_ca), 32'h1);
      rst = 1'b0;

      // 1: basic scan of 1234
      goto(1);  lit("prime", 4'b0000, 7'h00, 1'b0);
      goto(2);  lit("d0_first", 4'b0001, 7'h66, 1'b0);
      goto(5);  lit("d0_last", 4'b0001, 7'h66, 1'b0);
      goto(6);  lit("d1", 4'b0010, 7'h4F, 1'b0);
      goto(10); lit("d2", 4'b0100, 7'h5B, 1'b0);
      goto(14); lit("d3", 4'b1000, 7'h06, 1'b0);
      goto(16); chk("fd_before", 32'(frame_done), 32'd0);
      goto(17); chk("fd_pulse", 32'(frame_done), 32'd1);
      goto(18); chk("fd_after", 32'(frame_done), 32'd0);

      // 2: tearing, din changes while idx=1
      goto(22); din = 16'hFFFF;
      goto(26); lit("tear_d2", 4'b0100, 7'h5B, 1'b0);
      goto(30); lit("tear_d3", 4'b1000, 7'h06, 1'b0);
      goto(33); chk("fd_frame2", 32'(frame_done), 32'd1);
      goto(34); lit("new_d0", 4'b0001, 7'h71, 1'b0);
      // 3: blanking and decimal point
      blank = 4'b0100; dp_in = 4'b0001; din = 16'h8888;
      goto(46); lit("new_d3", 4'b1000, 7'h71, 1'b0);
      goto(50); lit("b_d0", 4'b0001, 7'h7F, 1'b1);
      din = 16'h0000; blank = 4'b0000; dp_in = 4'b0000;
      goto(54); lit("b_d1", 4'b0010, 7'h7F, 1'b0);
      goto(58); lit("b_d2_first", 4'b0000, 7'h00, 1'b0);
      goto(61); lit("b_d2_last", 4'b0000, 7'h00, 1'b0);
      goto(62); lit("b_d3", 4'b1000, 7'h7F, 1'b0);

      // 4: hold across a frame end; 6: inverted polarity on digit 0 of 0000
      goto(66); lit("zero_d0", 4'b0001, 7'h3F, 1'b0);
      chk("ca_d0_an", 32'(an_ca), 32'hE);
      chk("ca_d0_seg", 32'(seg_ca), 32'h40);
      din = 16'h9999; hold = 1'b1;
      goto(81); chk("fd_hold", 32'(frame_done), 32'd1);
      goto(82); lit("hold_d0", 4'b0001, 7'h3F, 1'b0);
      hold = 1'b0;
      goto(94); lit("hold_d3", 4'b1000, 7'h3F, 1'b0);
      goto(98); lit("nine_d0", 4'b0001, 7'h6F, 1'b0);

      // 5: asynchronous reset mid-slot at idx=2
      goto(107); lit("pre_rst_d2", 4'b0100, 7'h6F, 1'b0);
      #1 rst = 1'b1;
      #1;
      lit("async_rst", 4'b0000, 7'h00, 1'b0);
      chk("async_ca_an", 32'(an_ca), 32'hF);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      goto(1); lit("reprime", 4'b0000, 7'h00, 1'b0);
      goto(2); lit("reprime_d0", 4'b0001, 7'h6F, 1'b0);
      goto(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
